// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges stage stall requests, turns committed exceptions/ERET into a
// flush plus PC redirect, deferring the redirect past an outstanding fetch. Optional stall watchdog: STALL_WATCHDOG_EN.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [5:0]  ERET_TYPE  = 6'h0e,
  parameter int          WD_LIMIT   = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exr_valid,
  input  logic [5:0]  exr_type,
  input  logic [31:0] cp0_epc,
  output logic [4:0]  stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        wait_if,
  output logic        watchdog_timeout
);

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_IF = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] tgt_q;
  logic [31:0] tgt;

  assign tgt = (exr_type == ERET_TYPE) ? cp0_epc : EXC_VECTOR;

  // Outputs are combinational so a redirect with no fetch pending lands in the commit cycle.
  always_comb begin
    stall          = 5'b00000;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    wait_if        = 1'b0;
    case (state)
      RUN: begin
        if (exr_valid) begin
          flush = 1'b1;
          if (!stallreq_if) begin
            redirect_valid = 1'b1;
            redirect_pc    = tgt;
          end
        end else if (stallreq_mem) begin
          stall = 5'b11111;
        end else if (stallreq_ex) begin
          stall = 5'b01111;
        end else if (stallreq_id) begin
          stall = 5'b00111;
        end else if (stallreq_if) begin
          stall = 5'b00011;
        end
      end
      WAIT_IF: begin
        // Only the PC holds; everything behind it is flushed while the stale fetch drains.
        stall          = 5'b00001;
        flush          = 1'b1;
        wait_if        = 1'b1;
        redirect_pc    = tgt_q;
        redirect_valid = !stallreq_if;
      end
      default: begin
        stall = 5'b00000;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      tgt_q <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (exr_valid && stallreq_if) begin
            state <= WAIT_IF;
            tgt_q <= tgt;
          end
        end
        WAIT_IF: begin
          if (!stallreq_if) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef STALL_WATCHDOG_EN
  localparam logic [9:0] WD_MAX = 10'(WD_LIMIT);

  logic [9:0] wd_cnt;
  logic [9:0] wd_next;
  logic       wd_flag;

  always_comb begin
    wd_next = 10'd0;
    if (stall != 5'b00000) begin
      wd_next = (wd_cnt == 10'h3ff) ? wd_cnt : wd_cnt + 10'd1;
    end
  end

  // The flag rises on the same edge the counter reaches the limit and is sticky until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt  <= 10'd0;
      wd_flag <= 1'b0;
    end else begin
      wd_cnt <= wd_next;
      if (wd_next >= WD_MAX) begin
        wd_flag <= 1'b1;
      end
    end
  end

  assign watchdog_timeout = wd_flag;
`else
  assign watchdog_timeout = 1'b0;
`endif

endmodule
